// File: rtl/bean_eater_if.sv
`default_nettype none
// ============================================================================
// bean_eater_if : sweep request/status and RAM port B bus of the bean eater
// Revision      : 1.0
// ============================================================================
interface bean_eater_if;
    logic        start;
    logic [9:0]  px;
    logic [8:0]  py;
    logic        score_clr;
    logic [18:0] addr_b;
    logic        en_b;
    logic        we_b;
    logic        wdata_b;
    logic        rdata_b;
    logic        busy;
    logic        done;
    logic        eaten;
    logic [15:0] score;

    // master: the bean eater itself (drives the RAM port and the status)
    modport master (
        input  start, px, py, score_clr, rdata_b,
        output addr_b, en_b, we_b, wdata_b, busy, done, eaten, score
    );

    // slave: game logic plus the RAM port B it talks to
    modport slave (
        output start, px, py, score_clr, rdata_b,
        input  addr_b, en_b, we_b, wdata_b, busy, done, eaten, score
    );
endinterface
`default_nettype wire

// File: rtl/bean_eater.sv
`default_nettype none
// ============================================================================
// bean_eater : sweeps the sprite footprint in the bean bitmap, clears beans
//              and adds a saturating score once per sweep that ate something
// Revision   : 1.0
// ============================================================================
module bean_eater #(
    parameter int H_RES  = 640,
    parameter int V_RES  = 480,
    parameter int EAT_W  = 8,
    parameter int RD_LAT = 1,
    parameter int POINTS = 10
) (
    input  logic         clk,
    input  logic         rst,
    bean_eater_if.master bus
);
    localparam int c_DW = (EAT_W > 1) ? $clog2(EAT_W) : 1;
    localparam int c_LW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    localparam logic [c_DW-1:0] c_D_MAX    = c_DW'(EAT_W - 1);
    localparam logic [c_LW-1:0] c_LAT_LOAD = c_LW'(RD_LAT - 1);
    localparam logic [10:0]     c_X_LIM    = 11'(H_RES);
    localparam logic [9:0]      c_Y_LIM    = 10'(V_RES);
    localparam logic [18:0]     c_ROW      = 19'(H_RES);
    localparam logic [16:0]     c_PTS      = 17'(POINTS);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_READ  = 3'd1;
    localparam logic [2:0] c_WAIT  = 3'd2;
    localparam logic [2:0] c_CHECK = 3'd3;
    localparam logic [2:0] c_NEXT  = 3'd4;
    localparam logic [2:0] c_FIN   = 3'd5;

    logic [2:0]      r_state;
    logic [2:0]      w_next;
    logic [9:0]      r_px;
    logic [8:0]      r_py;
    logic [c_DW-1:0] r_dx;
    logic [c_DW-1:0] r_dy;
    logic [c_DW-1:0] w_nx_dx;
    logic [c_DW-1:0] w_nx_dy;
    logic [c_LW-1:0] r_lat;
    logic            r_hit;
    logic            r_rd_bit;
    logic [15:0]     r_score;

    logic [10:0]     w_cur_x;
    logic [9:0]      w_cur_y;
    logic [10:0]     w_nxt_x;
    logic [9:0]      w_nxt_y;
    logic            w_start_in;
    logic            w_nxt_in;
    logic            w_last;
    logic [18:0]     w_addr;
    logic [16:0]     w_sum;

    logic [18:0]     w_addr_b;
    logic            w_en_b;
    logic            w_we_b;
    logic            w_busy;
    logic            w_done;
    logic            w_eaten;

    // Footprint walk: dx runs fastest, wrapping into dy at the row end.
    always_comb begin
        w_last = (r_dx == c_D_MAX) && (r_dy == c_D_MAX);
        if (r_dx == c_D_MAX) begin
            w_nx_dx = '0;
            w_nx_dy = r_dy + 1'b1;
        end else begin
            w_nx_dx = r_dx + 1'b1;
            w_nx_dy = r_dy;
        end
    end

    // Sums are one bit wider than the coordinates so an off-screen pixel
    // can never alias back onto the screen.
    assign w_cur_x    = {1'b0, r_px} + 11'(r_dx);
    assign w_cur_y    = {1'b0, r_py} + 10'(r_dy);
    assign w_nxt_x    = {1'b0, r_px} + 11'(w_nx_dx);
    assign w_nxt_y    = {1'b0, r_py} + 10'(w_nx_dy);
    assign w_start_in = ({1'b0, bus.px} < c_X_LIM) && ({1'b0, bus.py} < c_Y_LIM);
    assign w_nxt_in   = (w_nxt_x < c_X_LIM) && (w_nxt_y < c_Y_LIM);
    assign w_addr     = 19'(w_cur_y) * c_ROW + 19'(w_cur_x);
    assign w_sum      = {1'b0, r_score} + c_PTS;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (bus.start) begin
                    w_next = w_start_in ? c_READ : c_NEXT;
                end
            end
            c_READ: begin
                w_next = c_WAIT;
            end
            c_WAIT: begin
                if (r_lat == '0) begin
                    w_next = c_CHECK;
                end
            end
            c_CHECK: begin
                w_next = c_NEXT;
            end
            c_NEXT: begin
                if (w_last) begin
                    w_next = c_FIN;
                end else if (w_nxt_in) begin
                    w_next = c_READ;
                end else begin
                    w_next = c_NEXT;
                end
            end
            c_FIN: begin
                w_next = c_IDLE;
            end
            default: begin
                w_next = c_IDLE;
            end
        endcase
    end

    always_comb begin
        w_addr_b = '0;
        w_en_b   = 1'b0;
        w_we_b   = 1'b0;
        w_busy   = 1'b1;
        w_done   = 1'b0;
        w_eaten  = 1'b0;
        case (r_state)
            c_IDLE: begin
                w_busy = 1'b0;
            end
            c_READ: begin
                w_addr_b = w_addr;
                w_en_b   = 1'b1;
            end
            c_WAIT: begin
                w_addr_b = w_addr;
            end
            c_CHECK: begin
                w_addr_b = w_addr;
                w_en_b   = r_rd_bit;
                w_we_b   = r_rd_bit;
            end
            c_NEXT: begin
                w_busy = 1'b1;
            end
            c_FIN: begin
                w_busy  = 1'b0;
                w_done  = 1'b1;
                w_eaten = r_hit;
            end
            default: begin
                w_busy = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_px     <= '0;
            r_py     <= '0;
            r_dx     <= '0;
            r_dy     <= '0;
            r_lat    <= '0;
            r_hit    <= 1'b0;
            r_rd_bit <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (bus.start) begin
                        r_px  <= bus.px;
                        r_py  <= bus.py;
                        r_dx  <= '0;
                        r_dy  <= '0;
                        r_hit <= 1'b0;
                    end
                end
                c_READ: begin
                    r_lat <= c_LAT_LOAD;
                end
                c_WAIT: begin
                    // Capture the bit on its valid cycle; CHECK acts on it.
                    if (r_lat == '0) begin
                        r_rd_bit <= bus.rdata_b;
                    end else begin
                        r_lat <= r_lat - 1'b1;
                    end
                end
                c_CHECK: begin
                    if (r_rd_bit) begin
                        r_hit <= 1'b1;
                    end
                end
                c_NEXT: begin
                    r_dx <= w_nx_dx;
                    r_dy <= w_nx_dy;
                end
                default: begin
                end
            endcase
        end
    end

    // A clear wins over the increment of a sweep finishing in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_score <= '0;
        end else if (bus.score_clr) begin
            r_score <= '0;
        end else if ((r_state == c_FIN) && r_hit) begin
            r_score <= w_sum[16] ? 16'hFFFF : w_sum[15:0];
        end
    end

    assign bus.addr_b  = w_addr_b;
    assign bus.en_b    = w_en_b;
    assign bus.we_b    = w_we_b;
    assign bus.wdata_b = 1'b0;
    assign bus.busy    = w_busy;
    assign bus.done    = w_done;
    assign bus.eaten   = w_eaten;
    assign bus.score   = r_score;
endmodule
`default_nettype wire

// File: tb/tb_bean_eater.sv
`default_nettype none
// ============================================================================
// tb_bean_eater : directed sweeps against a bitmap RAM model and scoreboard
// Revision      : 1.0
// ============================================================================
module tb_bean_eater;
    localparam int c_H     = 640;
    localparam int c_V     = 480;
    localparam int c_EAT   = 8;
    localparam int c_LAT   = 1;
    localparam int c_PTS   = 10;
    localparam int c_LIMIT = 2000;

    typedef struct {
        logic eaten;
        int   cycles;
        int   score;
    } res_t;

    logic clk = 1'b0;
    logic rst;
    int   n_pass  = 0;
    int   n_fail  = 0;
    int   n_total = 0;
    int   n_done  = 0;
    int   s_model = 0;

    logic [18:0] q_rd[$];
    logic [18:0] q_wr[$];
    res_t        q_res[$];
    bit          mem [0:c_H*c_V-1];

    always #5 clk = ~clk;

    bean_eater_if bif ();
    bean_eater_if sif ();

    bean_eater #(.H_RES(c_H), .V_RES(c_V), .EAT_W(c_EAT), .RD_LAT(c_LAT), .POINTS(c_PTS))
        dut (.clk(clk), .rst(rst), .bus(bif));

    // Single-pixel footprint on an always-set bitmap: every sweep is a hit.
    bean_eater #(.H_RES(c_H), .V_RES(c_V), .EAT_W(1), .RD_LAT(c_LAT), .POINTS(c_PTS))
        dut_sat (.clk(clk), .rst(rst), .bus(sif));

    assign sif.rdata_b = 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bitmap RAM, port B, one cycle read latency.
    always @(posedge clk) begin
        if (bif.en_b === 1'b1 && bif.addr_b < 19'(c_H*c_V)) begin
            if (bif.we_b === 1'b1) mem[bif.addr_b] = bif.wdata_b;
            else bif.rdata_b <= mem[bif.addr_b];
        end
    end

    always @(negedge clk) begin
        logic [18:0] exp_a;
        if (bif.done === 1'b1) n_done++;
        if (bif.en_b === 1'b1) begin
            chk("addr_bound", 32'(bif.addr_b < 19'(c_H*c_V)), 1);
            if (bif.we_b === 1'b1) begin
                exp_a = (q_wr.size() != 0) ? q_wr.pop_front() : 19'h7FFFF;
                chk("wr_addr", bif.addr_b, exp_a);
                chk("wr_data", bif.wdata_b, 0);
            end else begin
                exp_a = (q_rd.size() != 0) ? q_rd.pop_front() : 19'h7FFFF;
                chk("rd_addr", bif.addr_b, exp_a);
            end
        end
    end

    task automatic run_sweep(input int x, input int y, input bit mid_start,
                             input bit fin_start, input bit fin_clr);
        res_t r;
        int   cyc;
        int   d0;
        int   a;
        bit   hit;
        hit      = 1'b0;
        r.cycles = 2;
        for (int dy = 0; dy < c_EAT; dy++) begin
            for (int dx = 0; dx < c_EAT; dx++) begin
                if (x + dx < c_H && y + dy < c_V) begin
                    a = (y + dy) * c_H + x + dx;
                    q_rd.push_back(19'(a));
                    if (mem[a]) begin
                        q_wr.push_back(19'(a));
                        hit = 1'b1;
                    end
                    r.cycles += c_LAT + 3;
                end else begin
                    r.cycles += 1;
                end
            end
        end
        r.eaten = hit;
        if (fin_clr) s_model = 0;
        else if (hit) s_model = (s_model + c_PTS > 65535) ? 65535 : s_model + c_PTS;
        r.score = s_model;
        q_res.push_back(r);

        d0 = n_done;
        bif.px    = 10'(x);
        bif.py    = 9'(y);
        bif.start = 1'b1;
        cyc = 1;
        tick();
        bif.start = 1'b0;
        cyc = 2;
        while (bif.done !== 1'b1 && cyc < c_LIMIT) begin
            if (mid_start) begin
                bif.start = (cyc % 37 == 0);
                bif.px    = 10'($urandom_range(0, 1023));
                bif.py    = 9'($urandom_range(0, 511));
            end
            tick();
            cyc++;
        end
        r = q_res.pop_front();
        chk("done_seen", bif.done, 1);
        chk("cycles", cyc, r.cycles);
        chk("eaten", bif.eaten, r.eaten);
        bif.start     = fin_start;
        bif.score_clr = fin_clr;
        tick();
        bif.start     = 1'b0;
        bif.score_clr = 1'b0;
        chk("score", bif.score, r.score);
        chk("busy_idle", bif.busy, 0);
        tick();
        chk("busy_after", bif.busy, 0);
        chk("done_count", n_done - d0, 1);
        chk("rd_left", q_rd.size(), 0);
        chk("wr_left", q_wr.size(), 0);
    endtask

    initial begin
        int k;
        int n;
        rst = 1'b1;
        bif.start = 1'b0; bif.px = '0; bif.py = '0; bif.score_clr = 1'b0;
        sif.start = 1'b0; sif.px = '0; sif.py = '0; sif.score_clr = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        chk("rst_addr", bif.addr_b, 0);
        chk("rst_en", bif.en_b, 0);
        chk("rst_we", bif.we_b, 0);
        chk("rst_wdata", bif.wdata_b, 0);
        chk("rst_busy", bif.busy, 0);
        chk("rst_done", bif.done, 0);
        chk("rst_eaten", bif.eaten, 0);
        chk("rst_score", bif.score, 0);
        tick();

        run_sweep(100, 50, 1'b0, 1'b0, 1'b0);

        mem[32742] = 1'b1;
        mem[32743] = 1'b1;
        run_sweep(100, 50, 1'b0, 1'b0, 1'b0);
        chk("cleared_32742", mem[32742], 0);
        chk("cleared_32743", mem[32743], 0);

        run_sweep(636, 476, 1'b0, 1'b0, 1'b0);

        run_sweep(0, 0, 1'b1, 1'b1, 1'b0);

        // Reset lands in the cycle after the first READ of a sweep.
        mem[64200] = 1'b1;
        q_rd.push_back(19'd64200);
        bif.px = 10'd200; bif.py = 9'd100; bif.start = 1'b1;
        tick();
        bif.start = 1'b0;
        chk("mid_read_en", bif.en_b, 1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        s_model = 0;
        chk("mid_rst_en", bif.en_b, 0);
        chk("mid_rst_we", bif.we_b, 0);
        chk("mid_rst_busy", bif.busy, 0);
        chk("mid_rst_score", bif.score, 0);
        tick();
        chk("post_rst_en", bif.en_b, 0);
        chk("post_rst_bean", mem[64200], 1);
        chk("post_rst_rd_left", q_rd.size(), 0);
        run_sweep(200, 100, 1'b0, 1'b0, 1'b0);

        mem[1000] = 1'b1;
        run_sweep(360, 1, 1'b0, 1'b0, 1'b1);

        // 6553 hits of 10 points, then saturation.
        sif.start = 1'b1;
        k = 0;
        n = 0;
        while (k < 6553 && n < 50000) begin
            tick();
            n++;
            if (sif.done === 1'b1) k++;
        end
        chk("sat_sweeps", k, 6553);
        sif.start = 1'b0;
        tick();
        chk("sat_pre", sif.score, 65530);
        for (int i = 0; i < 2; i++) begin
            sif.start = 1'b1;
            tick();
            sif.start = 1'b0;
            n = 0;
            while (sif.done !== 1'b1 && n < 20) begin
                tick();
                n++;
            end
            chk("sat_eaten", sif.eaten, 1);
            tick();
            chk("sat_score", sif.score, 65535);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #10000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
